wt_mem_arbiter: RTL

- Parametrised N-port memory-side arbiter for the write-through cache subsystem. Generalises the fixed icache/dcache pairing to NumPorts cache clients (icache, dcache, extra accelerators) sharing one adapter request port.
- Round-robin grant, registered request stage, and an outstanding-transaction table that remaps client transaction IDs onto a shared memory ID space.
- Each return is routed back to the originating client.
- Sits between the L1 caches and the AXI/L15 adapter.

---
 rtl/wt_mem_arbiter_if.sv | 52 +++++
 rtl/wt_mem_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/wt_mem_arbiter_if.sv
// Client-side and memory-side bus bundle for wt_mem_arbiter.
// Performance counter signals exist only when WT_MEM_ARB_PERF_EN is defined.
interface wt_mem_arbiter_if #(
  parameter int NumPorts      = 3,
  parameter int ReqWidth      = 128,
  parameter int RtrnWidth     = 128,
  parameter int ClientIdWidth = 2,
  parameter int MaxTx         = 4
);
  localparam int MemIdWidth = $clog2(MaxTx);

  logic [NumPorts-1:0]                    req_i;
  logic [NumPorts-1:0][ReqWidth-1:0]      req_data_i;
  logic [NumPorts-1:0][ClientIdWidth-1:0] req_id_i;
  logic [NumPorts-1:0]                    ack_o;
  logic                                   mem_req_o;
  logic [ReqWidth-1:0]                    mem_data_o;
  logic [MemIdWidth-1:0]                  mem_id_o;
  logic                                   mem_ack_i;
  logic                                   mem_rtrn_vld_i;
  logic [MemIdWidth-1:0]                  mem_rtrn_id_i;
  logic [RtrnWidth-1:0]                   mem_rtrn_data_i;
  logic [NumPorts-1:0]                    rtrn_vld_o;
  logic [ClientIdWidth-1:0]               rtrn_id_o;
  logic [RtrnWidth-1:0]                   rtrn_data_o;
  logic                                   busy_o;
  logic                                   err_o;
`ifdef WT_MEM_ARB_PERF_EN
  logic [NumPorts-1:0][31:0]              perf_grant_cnt_o;
  logic [31:0]                            perf_full_cnt_o;

  modport slave (
    input  req_i, req_data_i, req_id_i, mem_ack_i, mem_rtrn_vld_i, mem_rtrn_id_i, mem_rtrn_data_i,
    output ack_o, mem_req_o, mem_data_o, mem_id_o, rtrn_vld_o, rtrn_id_o, rtrn_data_o, busy_o, err_o,
    output perf_grant_cnt_o, perf_full_cnt_o
  );
  modport master (
    output req_i, req_data_i, req_id_i, mem_ack_i, mem_rtrn_vld_i, mem_rtrn_id_i, mem_rtrn_data_i,
    input  ack_o, mem_req_o, mem_data_o, mem_id_o, rtrn_vld_o, rtrn_id_o, rtrn_data_o, busy_o, err_o,
    input  perf_grant_cnt_o, perf_full_cnt_o
  );
`else
  modport slave (
    input  req_i, req_data_i, req_id_i, mem_ack_i, mem_rtrn_vld_i, mem_rtrn_id_i, mem_rtrn_data_i,
    output ack_o, mem_req_o, mem_data_o, mem_id_o, rtrn_vld_o, rtrn_id_o, rtrn_data_o, busy_o, err_o
  );
  modport master (
    output req_i, req_data_i, req_id_i, mem_ack_i, mem_rtrn_vld_i, mem_rtrn_id_i, mem_rtrn_data_i,
    input  ack_o, mem_req_o, mem_data_o, mem_id_o, rtrn_vld_o, rtrn_id_o, rtrn_data_o, busy_o, err_o
  );
`endif
endinterface

// File: rtl/wt_mem_arbiter.sv
// N-port round-robin memory arbiter with client-ID to slot remapping and return routing.
// Define WT_MEM_ARB_PERF_EN to add per-port grant and table-full stall counters.
module wt_mem_arbiter #(
  parameter int NumPorts      = 3,
  parameter int ReqWidth      = 128,
  parameter int RtrnWidth     = 128,
  parameter int ClientIdWidth = 2,
  parameter int MaxTx         = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  wt_mem_arbiter_if.slave bus
);
  localparam int MemIdWidth = $clog2(MaxTx);
  localparam int PortWidth  = $clog2(NumPorts);

  logic                                  stage_vld_q, stage_vld_d;
  logic [ReqWidth-1:0]                   stage_data_q, stage_data_d;
  logic [MemIdWidth-1:0]                 stage_id_q, stage_id_d;
  logic [PortWidth-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [MaxTx-1:0]                      slot_busy_q, slot_busy_d;
  logic [MaxTx-1:0][PortWidth-1:0]       slot_port_q, slot_port_d;
  logic [MaxTx-1:0][ClientIdWidth-1:0]   slot_cid_q, slot_cid_d;
  logic [NumPorts-1:0]                   rtrn_vld_q, rtrn_vld_d;
  logic [ClientIdWidth-1:0]              rtrn_id_q, rtrn_id_d;
  logic [RtrnWidth-1:0]                  rtrn_data_q, rtrn_data_d;
  logic                                  err_q, err_d;

  logic                  any_req;
  logic                  any_free;
  logic                  load;
  logic [PortWidth-1:0]  winner;
  logic [MemIdWidth-1:0] free_idx;
  logic [NumPorts-1:0]   ack;

  // First requester at or after the pointer, wrapping around the port list.
  always_comb begin
    int   p;
    logic found;
    p      = 0;
    found  = 1'b0;
    winner = rr_ptr_q;
    for (int i = 0; i < NumPorts; i++) begin
      p = int'(rr_ptr_q) + i;
      if (p >= NumPorts) p = p - NumPorts;
      if (!found && bus.req_i[p]) begin
        found  = 1'b1;
        winner = PortWidth'(p);
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int s = MaxTx - 1; s >= 0; s--) begin
      if (!slot_busy_q[s]) free_idx = MemIdWidth'(s);
    end
  end

  // Allocation looks only at the registered free vector, so a slot freed by
  // this cycle's return becomes allocatable one cycle later.
  assign any_req  = |bus.req_i;
  assign any_free = ~&slot_busy_q;
  assign load     = (!stage_vld_q || bus.mem_ack_i) && any_req && any_free;

  always_comb begin
    stage_vld_d  = stage_vld_q;
    stage_data_d = stage_data_q;
    stage_id_d   = stage_id_q;
    rr_ptr_d     = rr_ptr_q;
    slot_busy_d  = slot_busy_q;
    slot_port_d  = slot_port_q;
    slot_cid_d   = slot_cid_q;
    rtrn_vld_d   = '0;
    rtrn_id_d    = rtrn_id_q;
    rtrn_data_d  = rtrn_data_q;
    err_d        = 1'b0;
    ack          = '0;

    if (bus.mem_rtrn_vld_i) begin
      if (slot_busy_q[bus.mem_rtrn_id_i]) begin
        rtrn_vld_d[slot_port_q[bus.mem_rtrn_id_i]] = 1'b1;
        rtrn_id_d                                  = slot_cid_q[bus.mem_rtrn_id_i];
        rtrn_data_d                                = bus.mem_rtrn_data_i;
        slot_busy_d[bus.mem_rtrn_id_i]             = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end

    if (load) begin
      ack[winner]           = 1'b1;
      stage_vld_d           = 1'b1;
      stage_data_d          = bus.req_data_i[winner];
      stage_id_d            = free_idx;
      slot_busy_d[free_idx] = 1'b1;
      slot_port_d[free_idx] = winner;
      slot_cid_d[free_idx]  = bus.req_id_i[winner];
      rr_ptr_d              = (winner == PortWidth'(NumPorts - 1)) ? '0 : winner + 1'b1;
    end else if (bus.mem_ack_i) begin
      stage_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_vld_q  <= 1'b0;
      stage_data_q <= '0;
      stage_id_q   <= '0;
      rr_ptr_q     <= '0;
      slot_busy_q  <= '0;
      slot_port_q  <= '0;
      slot_cid_q   <= '0;
      rtrn_vld_q   <= '0;
      rtrn_id_q    <= '0;
      rtrn_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      stage_vld_q  <= stage_vld_d;
      stage_data_q <= stage_data_d;
      stage_id_q   <= stage_id_d;
      rr_ptr_q     <= rr_ptr_d;
      slot_busy_q  <= slot_busy_d;
      slot_port_q  <= slot_port_d;
      slot_cid_q   <= slot_cid_d;
      rtrn_vld_q   <= rtrn_vld_d;
      rtrn_id_q    <= rtrn_id_d;
      rtrn_data_q  <= rtrn_data_d;
      err_q        <= err_d;
    end
  end

  assign bus.ack_o       = ack;
  assign bus.mem_req_o   = stage_vld_q;
  assign bus.mem_data_o  = stage_data_q;
  assign bus.mem_id_o    = stage_id_q;
  assign bus.rtrn_vld_o  = rtrn_vld_q;
  assign bus.rtrn_id_o   = rtrn_id_q;
  assign bus.rtrn_data_o = rtrn_data_q;
  assign bus.err_o       = err_q;
  assign bus.busy_o      = (|slot_busy_q) || stage_vld_q;

`ifdef WT_MEM_ARB_PERF_EN
  logic [31:0] full_cnt_q, full_cnt_d;

  for (genvar gi = 0; gi < NumPorts; gi++) begin : g_grant_cnt
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (load && (winner == PortWidth'(gi)) && (cnt_q != '1)) cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
    end

    assign bus.perf_grant_cnt_o[gi] = cnt_q;
  end

  always_comb begin
    full_cnt_d = full_cnt_q;
    if (any_req && !any_free && (full_cnt_q != '1)) full_cnt_d = full_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) full_cnt_q <= '0;
    else         full_cnt_q <= full_cnt_d;
  end

  assign bus.perf_full_cnt_o = full_cnt_q;
`endif
endmodule
